// File: rtl/ex_mem_stage.sv
// Execute-to-memory pipeline boundary: two-entry skid buffer (main + skid) with
// a registered upstream ready, flush, and a sticky halt that stops intake.
module ex_mem_stage #(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_aluResult,
  input  logic [DW-1:0] in_writeData,
  input  logic          in_memRead,
  input  logic          in_memWrite,
  input  logic          in_regWrite,
  input  logic [RW-1:0] in_writeReg,
  input  logic          in_memToReg,
  input  logic          in_halt,
  input  logic          flush,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] aluResult,
  output logic [DW-1:0] writeData,
  output logic          memRead,
  output logic          memWrite,
  output logic          regWrite,
  output logic [RW-1:0] writeReg,
  output logic          memToReg,
  output logic          halt,
  output logic          halted
);

  typedef struct packed {
    logic [DW-1:0] aluResult;
    logic [DW-1:0] writeData;
    logic          memRead;
    logic          memWrite;
    logic          regWrite;
    logic [RW-1:0] writeReg;
    logic          memToReg;
    logic          halt;
  } bundle_t;

  bundle_t inBundle, mainReg, skidReg;
  logic    mainValid, skidValid;
  logic    accept, consume;

  always_comb begin
    inBundle.aluResult = in_aluResult;
    inBundle.writeData = in_writeData;
    inBundle.memRead   = in_memRead;
    inBundle.memWrite  = in_memWrite;
    inBundle.regWrite  = in_regWrite;
    inBundle.writeReg  = in_writeReg;
    inBundle.memToReg  = in_memToReg;
    inBundle.halt      = in_halt;
  end

  // in_ready depends only on registered state, never on out_ready or in_valid
  always_comb begin
    in_ready = ~skidValid & ~halted;
    accept   = in_valid & in_ready;
    consume  = mainValid & out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mainValid <= 1'b0;
      skidValid <= 1'b0;
      halted    <= 1'b0;
      mainReg   <= '0;
      skidReg   <= '0;
    end else if (flush) begin
      mainValid <= 1'b0;
      skidValid <= 1'b0;
      halted    <= 1'b0;
    end else begin
      if (accept && in_halt)
        halted <= 1'b1;
      // skid full implies main full and no accept this cycle
      if (skidValid) begin
        if (consume) begin
          mainReg   <= skidReg;
          skidValid <= 1'b0;
        end
      end else if (!mainValid) begin
        if (accept) begin
          mainReg   <= inBundle;
          mainValid <= 1'b1;
        end
      end else begin
        if (consume && accept) begin
          mainReg <= inBundle;
        end else if (consume) begin
          mainValid <= 1'b0;
        end else if (accept) begin
          skidReg   <= inBundle;
          skidValid <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    out_valid = mainValid;
    aluResult = mainReg.aluResult;
    writeData = mainReg.writeData;
    writeReg  = mainReg.writeReg;
    memToReg  = mainReg.memToReg;
    memRead   = mainReg.memRead  & mainValid;
    memWrite  = mainReg.memWrite & mainValid;
    regWrite  = mainReg.regWrite & mainValid;
    halt      = mainReg.halt     & mainValid;
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios plus random traffic, checked each
// cycle against a queue-based FIFO model of the stage.
module tb_ex_mem_stage;
  localparam int DW = 16;
  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_aluResult, in_writeData;
  logic          in_memRead, in_memWrite, in_regWrite, in_memToReg, in_halt;
  logic [RW-1:0] in_writeReg;
  logic          flush, out_ready, out_valid;
  logic [DW-1:0] aluResult, writeData;
  logic          memRead, memWrite, regWrite, memToReg, halt, halted;
  logic [RW-1:0] writeReg;

  ex_mem_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_aluResult(in_aluResult), .in_writeData(in_writeData),
    .in_memRead(in_memRead), .in_memWrite(in_memWrite), .in_regWrite(in_regWrite),
    .in_writeReg(in_writeReg), .in_memToReg(in_memToReg), .in_halt(in_halt),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .aluResult(aluResult), .writeData(writeData),
    .memRead(memRead), .memWrite(memWrite), .regWrite(regWrite),
    .writeReg(writeReg), .memToReg(memToReg), .halt(halt), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] aluResult;
    logic [DW-1:0] writeData;
    logic          memRead;
    logic          memWrite;
    logic          regWrite;
    logic [RW-1:0] writeReg;
    logic          memToReg;
    logic          halt;
  } bun_t;

  // Model: the stage is a FIFO of capacity 2; intake blocked when full or halted
  bun_t q[$];
  logic mHalted;
  int   total = 0;
  int   bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bun_t mk(input logic [DW-1:0] a, input logic [DW-1:0] w,
                              input logic mr, input logic mw, input logic rw,
                              input logic [RW-1:0] wr, input logic m2r, input logic h);
    bun_t b;
    b.aluResult = a; b.writeData = w; b.memRead = mr; b.memWrite = mw;
    b.regWrite = rw; b.writeReg = wr; b.memToReg = m2r; b.halt = h;
    return b;
  endfunction

  task automatic checkModel();
    bun_t h;
    logic v;
    v = (q.size() > 0);
    h = v ? q[0] : '0;
    check("out_valid", 32'(out_valid), 32'(v));
    check("in_ready", 32'(in_ready), 32'(q.size() < 2 && !mHalted));
    check("halted", 32'(halted), 32'(mHalted));
    check("memRead", 32'(memRead), 32'(h.memRead));
    check("memWrite", 32'(memWrite), 32'(h.memWrite));
    check("regWrite", 32'(regWrite), 32'(h.regWrite));
    check("halt", 32'(halt), 32'(h.halt));
    if (v) begin
      check("aluResult", 32'(aluResult), 32'(h.aluResult));
      check("writeData", 32'(writeData), 32'(h.writeData));
      check("writeReg", 32'(writeReg), 32'(h.writeReg));
      check("memToReg", 32'(memToReg), 32'(h.memToReg));
    end
  endtask

  task automatic cycle(input logic v, input bun_t b, input logic fl, input logic ordy, input logic rs);
    logic acc, con;
    checkModel();
    rst = rs; in_valid = v; flush = fl; out_ready = ordy;
    in_aluResult = b.aluResult; in_writeData = b.writeData;
    in_memRead = b.memRead; in_memWrite = b.memWrite; in_regWrite = b.regWrite;
    in_writeReg = b.writeReg; in_memToReg = b.memToReg; in_halt = b.halt;
    acc = v && q.size() < 2 && !mHalted;
    con = (q.size() > 0) && ordy;
    @(posedge clk);
    if (rs || fl) begin
      q.delete();
      mHalted = 1'b0;
    end else begin
      if (con) void'(q.pop_front());
      if (acc) begin
        q.push_back(b);
        if (b.halt) mHalted = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  bun_t idle, rb;

  initial begin
    idle = '0;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_aluResult = '0; in_writeData = '0; in_memRead = 1'b0; in_memWrite = 1'b0;
    in_regWrite = 1'b0; in_writeReg = '0; in_memToReg = 1'b0; in_halt = 1'b0;
    q.delete();
    mHalted = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_aluResult", 32'(aluResult), 32'd0);

    // Streaming at full throughput
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, mk(16'(16'h0010 + 2 * i), 16'h0, 1'b0, 1'b0, 1'b1, 3'(i), 1'b0, 1'b0), 1'b0, 1'b1, 1'b0);
      check("stream_head", 32'(aluResult), 32'(16'h0010 + 2 * i));
    end
    cycle(1'b0, idle, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, idle, 1'b0, 1'b1, 1'b0);

    // Memory stall pushes the second bundle into skid
    cycle(1'b1, mk(16'h0040, 16'hBEEF, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, mk(16'h0042, 16'h1234, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0);
    cycle(1'b0, idle, 1'b0, 1'b0, 1'b0);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_head", 32'(aluResult), 32'h0040);
    check("stall_memWrite", 32'(memWrite), 32'd1);
    cycle(1'b0, idle, 1'b0, 1'b1, 1'b0);
    check("drain_second", 32'(aluResult), 32'h0042);
    cycle(1'b0, idle, 1'b0, 1'b1, 1'b0);
    check("drain_in_ready", 32'(in_ready), 32'd1);

    // Bubble gating
    cycle(1'b0, mk(16'h0, 16'h0, 1'b1, 1'b1, 1'b1, 3'd5, 1'b1, 1'b1), 1'b0, 1'b1, 1'b0);
    check("bubble_memWrite", 32'(memWrite), 32'd0);
    check("bubble_regWrite", 32'(regWrite), 32'd0);

    // Flush with both entries full and a competing accept
    cycle(1'b1, mk(16'h0100, 16'h0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, mk(16'h0102, 16'h0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, mk(16'h0DEA, 16'h0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    cycle(1'b0, idle, 1'b0, 1'b1, 1'b0);

    // Halt stops intake until flush
    cycle(1'b1, mk(16'h00FF, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_in_ready", 32'(in_ready), 32'd0);
    check("halt_pulse", 32'(halt), 32'd1);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, mk(16'h0200, 16'h0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0), 1'b0, 1'b1, 1'b0);
    check("halt_no_intake", 32'(out_valid), 32'd0);
    cycle(1'b0, idle, 1'b1, 1'b1, 1'b0);

    // Reset while skid full and memory stalled
    cycle(1'b1, mk(16'h0300, 16'hAAAA, 1'b1, 1'b1, 1'b1, 3'd7, 1'b1, 1'b0), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, mk(16'h0302, 16'h5555, 1'b1, 1'b1, 1'b1, 3'd6, 1'b1, 1'b0), 1'b0, 1'b0, 1'b0);
    cycle(1'b0, idle, 1'b0, 1'b0, 1'b1);
    check("rst2_out_valid", 32'(out_valid), 32'd0);
    check("rst2_in_ready", 32'(in_ready), 32'd1);
    check("rst2_halted", 32'(halted), 32'd0);
    check("rst2_data", 32'({aluResult, writeData}), 32'd0);
    check("rst2_ctrl", 32'({memRead, memWrite, regWrite, writeReg, memToReg, halt}), 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rb = mk(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              3'($urandom), 1'($urandom), $urandom_range(15) == 0);
      cycle($urandom_range(9) < 7, rb, $urandom_range(31) == 0, $urandom_range(9) < 6,
            $urandom_range(99) == 0);
    end
    checkModel();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline boundary between execute and the memory stage (memory2c wrapper). Registers the execute result bundle and presents it to memory with a valid/ready handshake.
- Contains a 2-entry skid buffer (main + skid register) so the upstream ready is a pure register output. A memory-side stall therefore never forms a combinational path back into execute.
- Supports flush (branch mispredict or exception) and a sticky halt that stops intake after a halt instruction is accepted.

Parameters:
- DW, 16, data/address width (aluResult, writeData)
- RW, 3, destination register index width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  execute presents a valid bundle
- in_ready  out  1  stage can accept a bundle this cycle
- in_aluResult  in  DW  ALU result / memory address
- in_writeData  in  DW  store data
- in_memRead  in  1  load
- in_memWrite  in  1  store
- in_regWrite  in  1  writes register file
- in_writeReg  in  RW  destination register
- in_memToReg  in  1  writeback selects memory data
- in_halt  in  1  halt/dump instruction
- flush  in  1  discard all buffered bundles
- out_ready  in  1  memory stage consumes the head bundle (0 = memory stall)
- out_valid  out  1  head bundle valid
- aluResult, writeData  out  DW  head bundle data
- memRead, memWrite, regWrite, memToReg, halt  out  1  head control, gated by out_valid
- writeReg  out  RW  head destination register
- halted  out  1  sticky: halt bundle accepted

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset state: main_valid=0, skid_valid=0, halted=0; all data/control registers 0. Consequently out_valid=0, in_ready=1 in the first cycle after reset deasserts. Reset mid-transfer discards everything; no bundle survives.
- Handshake rules:
  - Accept = in_valid & in_ready.
  - Consume = out_valid & out_ready.
  - in_ready = ~skid_valid & ~halted. It is registered state only, with no combinational path from out_ready or in_valid.
- Head outputs:
  - The head is always the main register; out_valid = main_valid.
  - memRead, memWrite, regWrite and halt are ANDed with main_valid, so memory never acts on a bubble.
  - aluResult, writeData, writeReg and memToReg show the main register contents unmasked.
- Next-state table, with flush=0:
  - main empty, accept: bundle goes into main. Latency 1 cycle from accept to out_valid.
  - main full, consume, no accept: main empties.
  - main full, consume, accept: bundle goes into main (pass-through, throughput 1/cycle).
  - main full, no consume, accept: bundle goes into skid; skid_valid=1, so in_ready=0 next cycle.
  - skid full, consume: skid moves to main; skid_valid=0. Accept is impossible this cycle (in_ready=0).
  - Order is strictly FIFO; no bundle is dropped or duplicated.
- Flush:
  - Next cycle main_valid=0, skid_valid=0, halted=0.
  - Flush has priority over any accept in the same cycle; the bundle is discarded.
  - A consume in the flush cycle still completes: memory sees the head that cycle.
- Halt:
  - Accepting a bundle with in_halt=1 sets halted, so in_ready=0 from the next cycle.
  - The halt bundle and any earlier bundles drain normally; the halt output pulses with its bundle at the head.
  - halted clears only on rst or flush.
- Data registers load only on their own capture event and hold otherwise. No X propagation from idle inputs.
- No arithmetic; widths are passed through unchanged.

Test Plan:
- Reset, then stream 4 bundles aluResult=0x0010,0x0012,0x0014,0x0016 with out_ready=1 -> out_valid from cycle after the first accept; outputs in order, one per cycle; in_ready stays 1.
- Store aluResult=0x0040, writeData=0xBEEF, memWrite=1, with out_ready=0 for 3 cycles plus a second bundle 0x0042 -> second bundle goes to skid, in_ready=0. The head holds 0x0040 with memWrite=1 throughout. After out_ready=1, 0x0040 then 0x0042 appear on consecutive cycles and in_ready returns to 1.
- Bubble gating: in_valid=0 but in_memWrite=1, in_regWrite=1 -> out_valid=0, memWrite=0, regWrite=0.
- Flush with main and skid full and in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1; the flushed-cycle input never appears at the outputs.
- Halt bundle (in_halt=1, aluResult=0x00FF) accepted, then in_valid=1 held -> halted=1 and in_ready=0 next cycle. The halt bundle reaches the head with halt=1; later bundles are never accepted until flush.
- rst asserted while skid full and out_ready=0 -> next cycle out_valid=0, halted=0, in_ready=1, all outputs 0.
